// File: rtl/i2c_reg_reader.sv
// rtl/i2c_reg_reader.sv - I2C master register read: START, addr+W, reg, RSTART, addr+R, N bytes, STOP
// Optional build macro: I2C_CLK_STRETCH_EN (hold bit timing while a slave stretches SCL low).
module i2c_reg_reader #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [7:0]             reg_addr,
  input  logic [CNT_W-1:0]       nbytes,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic [8*MAX_BYTES-1:0] rdata,
  inout  wire                    i2c_sclk,
  inout  wire                    i2c_sdat
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_AW, REG, ACK_R, RSTART,
    ADDR_R, ACK_AR, READ, MACK, STOP, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] n_eff_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic             ack_bit;
  logic             scl_low;
  logic             sda_low;
  logic             stall;
  logic             tick;
  logic             bit_end;
  logic             sample;
  logic             last_byte;
  logic [7:0]       tx_byte;
  logic             tx_bit;
  logic             sda_in;

  // Open-drain pads: only ever pull low, otherwise release to the pull-ups.
  assign i2c_sclk = scl_low ? 1'b0 : 1'bz;
  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
  assign sda_in   = i2c_sdat;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we have it released freezes the bit timer.
  assign stall = ((phase == 2'd1) || (phase == 2'd2)) && (i2c_sclk == 1'b0);
`else
  assign stall = 1'b0;
`endif

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1)) && !stall;
  assign bit_end   = tick && (phase == 2'd3);
  assign sample    = tick && (phase == 2'd1);
  assign last_byte = (byte_cnt == (n_eff_q - CNT_W'(1)));
  assign tx_bit    = tx_byte[~bit_cnt];

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

  // Effective byte count: 0 reads one byte, oversize requests clamp to MAX_BYTES.
  always_comb begin
    n_eff = nbytes;
    if (nbytes == '0) begin
      n_eff = CNT_W'(1);
    end else if (nbytes > CNT_W'(MAX_BYTES)) begin
      n_eff = CNT_W'(MAX_BYTES);
    end
  end

  // Byte currently being shifted out by the master.
  always_comb begin
    tx_byte = reg_q;
    case (state)
      ADDR_W:  tx_byte = {dev_q, 1'b0};
      ADDR_R:  tx_byte = {dev_q, 1'b1};
      default: tx_byte = reg_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-phase pad drive; SCL is low in phases 0 and 3 of ordinary bits.
  always_comb begin
    state_nxt = state;
    scl_low   = 1'b0;
    sda_low   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = START;
      end
      START: begin
        scl_low = (phase == 2'd3);
        sda_low = (phase >= 2'd2);
        if (bit_end) state_nxt = ADDR_W;
      end
      ADDR_W, REG, ADDR_R: begin
        scl_low = (phase == 2'd0) || (phase == 2'd3);
        sda_low = !tx_bit;
        if (bit_end && (bit_cnt == 3'd7)) begin
          case (state)
            ADDR_W:  state_nxt = ACK_AW;
            REG:     state_nxt = ACK_R;
            default: state_nxt = ACK_AR;
          endcase
        end
      end
      ACK_AW, ACK_R, ACK_AR: begin
        scl_low = (phase == 2'd0) || (phase == 2'd3);
        if (bit_end) begin
          if (ack_bit) begin
            state_nxt = STOP;
          end else begin
            case (state)
              ACK_AW:  state_nxt = REG;
              ACK_R:   state_nxt = RSTART;
              default: state_nxt = READ;
            endcase
          end
        end
      end
      RSTART: begin
        scl_low = (phase == 2'd0) || (phase == 2'd3);
        sda_low = (phase >= 2'd2);
        if (bit_end) state_nxt = ADDR_R;
      end
      READ: begin
        scl_low = (phase == 2'd0) || (phase == 2'd3);
        if (bit_end && (bit_cnt == 3'd7)) state_nxt = MACK;
      end
      MACK: begin
        scl_low = (phase == 2'd0) || (phase == 2'd3);
        sda_low = !last_byte;
        if (bit_end) state_nxt = last_byte ? STOP : READ;
      end
      STOP: begin
        scl_low = (phase == 2'd0);
        sda_low = (phase <= 2'd1);
        if (bit_end) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bit timer, request latching, ACK sampling and read-data shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      n_eff_q  <= CNT_W'(1);
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      ack_bit  <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= '0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      if (start) begin
        dev_q   <= dev_addr;
        reg_q   <= reg_addr;
        n_eff_q <= n_eff;
        ack_bit <= 1'b0;
        ack_err <= 1'b0;
        rdata   <= '0;
      end
    end else begin
      if (tick) begin
        div_cnt <= '0;
        phase   <= phase + 2'd1;
      end else if (!stall) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (sample) begin
        case (state)
          ACK_AW, ACK_R, ACK_AR: begin
            ack_bit <= sda_in;
            if (sda_in) ack_err <= 1'b1;
          end
          READ: begin
            rdata <= {rdata[8*MAX_BYTES-2:0], sda_in};
          end
          default: begin
          end
        endcase
      end
      if (bit_end) begin
        case (state)
          ADDR_W, REG, ADDR_R, READ: bit_cnt <= bit_cnt + 3'd1;
          MACK:                      byte_cnt <= byte_cnt + CNT_W'(1);
          default: begin
          end
        endcase
      end
    end
  end

endmodule
